seq_mult_unsigned: RTL
======================

Name: seq_mult_unsigned

Overview:
- Sequential unsigned shift-and-add multiplier with a start/done handshake.
- Counterpart to the team's sequential unsigned divider: it rebuilds a dividend from divisor and quotient, so the divider bench can use it as an on-chip checker (q*d + r == dividend).
- Single FSM plus datapath: accumulator, multiplier shift register, iteration counter.
- Processes one multiplier bit per clock.

Parameters:
- WIDTH, 8, operand width in bits (>= 2); product is 2*WIDTH bits.

Ports:
- i_clk  input  1  rising-edge clock.
- i_rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  multiplicand; captured on the accepting edge.
- b  input  WIDTH  multiplier; captured on the accepting edge.
- busy  output  1  high from the cycle after acceptance through the last CALC cycle.
- done  output  1  one-cycle pulse; product valid.
- product  output  2*WIDTH  result; held from the done pulse until the next accepted start.

Behaviour:
- Clock and reset: one clock (i_clk). Reset is asynchronous, active-high (i_rst); all registers clear immediately on assertion.
- Reset values: state=IDLE, busy=0, done=0, product=0, accumulator=0, multiplicand register=0, multiplier register=0, count=0.
- All outputs are driven directly from registers; no combinational path from inputs to outputs.
- States: IDLE(2'b00), CALC(2'b01), DONE(2'b10). 2'b11 is illegal and goes to IDLE on the next edge with busy=0 and done=0.
- IDLE:
  - If start=1 on an edge: M<=a, Q<=b, ACC (WIDTH+1 bits)<=0, count<=WIDTH, busy<=1, state<=CALC.
  - If start=0: hold; product is unchanged.
- CALC, per edge:
  - sum = ACC + (Q[0] ? {1'b0,M} : 0), computed at WIDTH+1 bits; the carry is kept in the MSB.
  - Then {ACC,Q} <= {sum,Q} >> 1, with a zero shifted into the MSB.
  - count <= count-1.
  - On the edge where count==1: product <= the shifted {ACC[WIDTH-1:0],Q}, busy<=0, done<=1, state<=DONE.
- DONE: done=1 for exactly this one cycle. The next edge sets done<=0 and state<=IDLE.
- Latency:
  - start accepted at edge E0.
  - busy high in cycles E0+1 .. E0+WIDTH.
  - done and the new product visible after edge E0+WIDTH.
  - Earliest next acceptance is edge E0+WIDTH+2.
- start while busy or in DONE: ignored. It is not queued and does not disturb the operation. a and b may change freely after acceptance.
- Overflow: impossible. The full 2*WIDTH product is always exact, e.g. (2^WIDTH-1)^2.
- Zero operands: all WIDTH iterations still run; latency is constant and data-independent.
- Reset mid-operation: asynchronous abort.
  - All registers return to reset values, including product=0.
  - No done pulse is produced for the aborted operation.
  - The first start after reset deassertion is accepted normally.
- Back-to-back: start held high continuously results in a new acceptance every WIDTH+2 cycles, each using the a/b present on its accepting edge.

Test Plan:
- WIDTH=8, a=13, b=11, start pulse 1 cycle -> busy high 8 cycles, done pulse on cycle 9 after acceptance, product=143, held until the next start.
- a=255, b=255 -> product=65025 (16'hFE01); checks carry into the ACC MSB. Then a=0, b=200 -> product=0 with the same 8-cycle latency.
- a=1, b=255 and a=255, b=1 -> product=255 in both cases. Also a=128, b=2 -> product=256.
- Accept a=6, b=7, then pulse start with a=9, b=9 at cycles 3 and 9 after acceptance (during busy and during DONE) -> product=42, exactly one done pulse, no second operation started.
- Accept a=200, b=100, assert i_rst asynchronously mid-clock at cycle 4 -> busy, done and product go to 0 immediately, no done pulse follows. Accept a=3, b=5 after release -> product=15.
- Random regression: 1000 random a/b with start held high -> each product == a*b, done spacing exactly 10 cycles, busy never high in a done cycle.

Source files
------------

// File: rtl/seq_mult_unsigned.sv
// seq_mult_unsigned: shift-and-add unsigned multiplier, one multiplier bit per clock, start/done handshake
module seq_mult_unsigned #(
  parameter int WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE = 2'b00, CALC = 2'b01, DONE = 2'b10} state_t;
  state_t state, state_n;
  logic [WIDTH:0] acc, sum;
  logic [WIDTH-1:0] m, q;
  logic [CW-1:0] count;
  // state register; the unused 2'b11 encoding falls back to IDLE through state_n
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) state <= IDLE;
    else state <= state_n;
  // partial-product add (carry kept in acc MSB) and next-state selection
  always_comb begin
    sum = acc + (q[0] ? {1'b0, m} : '0);
    state_n = state == IDLE ? (start ? CALC : IDLE) :
              state == CALC ? (count == CW'(1) ? DONE : CALC) : IDLE;
  end
  // datapath: capture operands, shift {acc,q} right once per CALC cycle, publish on the last one
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      acc     <= '0;
      m       <= '0;
      q       <= '0;
      count   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      busy <= state_n == CALC;
      done <= state_n == DONE;
      if (state == IDLE && start) begin
        m     <= a;
        q     <= b;
        acc   <= '0;
        count <= CW'(WIDTH);
      end else if (state == CALC) begin
        acc   <= {1'b0, sum[WIDTH:1]};
        q     <= {sum[0], q[WIDTH-1:1]};
        count <= count - CW'(1);
        if (count == CW'(1)) product <= {sum, q[WIDTH-1:1]};
      end
    end
endmodule
